// File: rtl/ultrasonic_ping_sched_pkg.sv
// Shared definitions for the ultrasonic ping sequencer: state encoding and
// prescaler sizing helpers.
package ultrasonic_ping_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TX      = 3'd1,
      ST_BLANK   = 3'd2,
      ST_LISTEN  = 3'd3,
      ST_HOLDOFF = 3'd4
   } state_t;

   localparam int C_HZ_PER_MHZ = 1_000_000;

   function automatic int f_us_div(input int f_ck);
      return f_ck / C_HZ_PER_MHZ;
   endfunction

   function automatic int f_clog2(input int v);
      int w;
      w = 1;
      while ((1 << w) < v) w++;
      return w;
   endfunction

endpackage

// File: rtl/ultrasonic_ping_sched_us_tick_gen.sv
// Microsecond prescaler: TICK_o pulses once every C_DIV clocks, counting
// restarts from zero on the clock after CLR_i.
module us_tick_gen
   import ultrasonic_ping_sched_pkg::*;
#(
   parameter int C_DIV = 100
) (
   input  logic CK_i,
   input  logic RST_i,
   input  logic CLR_i,
   output logic TICK_o
);

   localparam int C_CNT_W = f_clog2(C_DIV);
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_DIV - 1);

   logic [C_CNT_W-1:0] r_cnt;

   assign TICK_o = (r_cnt == C_LAST);

   always_ff @(posedge CK_i) begin
      if (RST_i || CLR_i) begin
         r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ultrasonic_ping_sched.sv
// Ping sequencer for the ultrasonic oscillator/DSDAC transmit path: burst,
// ring-down blanking, listen with first-echo timestamp, optional repeat.
//
// state   | meaning
// IDLE    | waiting for START_i or RUN_i; config latched on exit
// TX      | TX_EN_o high, counting oscillator wave wraps up to BURST_N
// BLANK   | ring-down window, echoes ignored
// LISTEN  | first synchronised echo edge is timestamped
// HOLDOFF | repeat delay while RUN_i stays high
module ultrasonic_ping_sched
   import ultrasonic_ping_sched_pkg::*;
#(
   parameter int C_F_CK   = 100_000_000,
   parameter int C_TIME_W = 16
) (
   input  logic                CK_i,
   input  logic                RST_i,
   input  logic                START_i,
   input  logic                RUN_i,
   input  logic [7:0]          BURST_N_i,
   input  logic [7:0]          WAVE_CYCLEs_i,
   input  logic                WAVE_IS_SAW_i,
   input  logic [C_TIME_W-1:0] BLANK_US_i,
   input  logic [C_TIME_W-1:0] LISTEN_US_i,
   input  logic [C_TIME_W-1:0] REPEAT_US_i,
   input  logic                WAVE_WRAP_i,
   input  logic                ECHO_i,
   output logic [7:0]          BUS_WAVE_CYCLEs_o,
   output logic                BUS_WAVE_IS_SAW_o,
   output logic                TX_EN_o,
   output logic                BUSY_o,
   output logic [C_TIME_W-1:0] ECHO_US_o,
   output logic                ECHO_VALID_o,
   output logic                TIMEOUT_o,
   output logic                DONE_o,
   output logic [2:0]          STATE_o
);

   localparam int C_US_DIV = f_us_div(C_F_CK);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_ping_start;
   logic                w_listen_end;
   logic                w_state_chg;
   logic                w_tick;
   logic                w_echo_rise;
   logic                w_capture;

   logic                r_echo_s1;
   logic                r_echo_s2;
   logic                r_echo_d;
   logic [7:0]          r_burst_n;
   logic [7:0]          r_wave_cnt;
   logic [C_TIME_W-1:0] r_blank_us;
   logic [C_TIME_W-1:0] r_listen_us;
   logic [C_TIME_W-1:0] r_repeat_us;
   logic [C_TIME_W-1:0] r_tmr;
   logic [C_TIME_W-1:0] r_elapsed;
   logic [C_TIME_W-1:0] r_echo_us;
   logic [7:0]          r_bus_wave_cycles;
   logic                r_bus_wave_is_saw;
   logic                r_echo_valid;
   logic                r_timeout;
   logic                r_done;

   us_tick_gen #(
      .C_DIV (C_US_DIV)
   ) u_tick (
      .CK_i   (CK_i),
      .RST_i  (RST_i),
      .CLR_i  (w_state_chg),
      .TICK_o (w_tick)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_ping_start = 1'b0;
      w_listen_end = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (START_i || RUN_i) begin
               w_ping_start = 1'b1;
               w_state_nxt  = (BURST_N_i == 8'd0) ? ST_BLANK : ST_TX;
            end
         end
         ST_TX: begin
            if (WAVE_WRAP_i && ((r_wave_cnt + 8'd1) == r_burst_n)) begin
               w_state_nxt = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (r_tmr == r_blank_us) begin
               w_state_nxt = ST_LISTEN;
            end
         end
         ST_LISTEN: begin
            if (r_tmr == r_listen_us) begin
               w_listen_end = 1'b1;
               w_state_nxt  = RUN_i ? ST_HOLDOFF : ST_IDLE;
            end
         end
         ST_HOLDOFF: begin
            if (!RUN_i) begin
               w_state_nxt = ST_IDLE;
            end else if (r_tmr == r_repeat_us) begin
               w_ping_start = 1'b1;
               w_state_nxt  = (BURST_N_i == 8'd0) ? ST_BLANK : ST_TX;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_state_chg = (w_state_nxt != r_state) || w_ping_start;
   assign w_echo_rise = r_echo_s2 && !r_echo_d;
   // An edge on the listen-expiry clock still counts as the echo.
   assign w_capture   = (r_state == ST_LISTEN) && w_echo_rise && !r_echo_valid;

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         r_state           <= ST_IDLE;
         r_echo_s1         <= 1'b0;
         r_echo_s2         <= 1'b0;
         r_echo_d          <= 1'b0;
         r_burst_n         <= '0;
         r_wave_cnt        <= '0;
         r_blank_us        <= '0;
         r_listen_us       <= '0;
         r_repeat_us       <= '0;
         r_tmr             <= '0;
         r_elapsed         <= '0;
         r_echo_us         <= '0;
         r_bus_wave_cycles <= '0;
         r_bus_wave_is_saw <= 1'b0;
         r_echo_valid      <= 1'b0;
         r_timeout         <= 1'b0;
         r_done            <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_echo_s1 <= ECHO_i;
         r_echo_s2 <= r_echo_s1;
         r_echo_d  <= r_echo_s2;
         r_done    <= w_listen_end;

         if (w_state_chg) begin
            r_tmr <= '0;
         end else if (w_tick && (r_tmr != '1)) begin
            r_tmr <= r_tmr + 1'b1;
         end

         if (w_ping_start) begin
            r_elapsed <= '0;
         end else if (w_tick && (r_state != ST_IDLE) && (r_elapsed != '1)) begin
            r_elapsed <= r_elapsed + 1'b1;
         end

         if (w_ping_start) begin
            r_wave_cnt <= '0;
         end else if ((r_state == ST_TX) && WAVE_WRAP_i) begin
            r_wave_cnt <= r_wave_cnt + 1'b1;
         end

         if (w_ping_start) begin
            r_burst_n         <= BURST_N_i;
            r_blank_us        <= BLANK_US_i;
            r_listen_us       <= LISTEN_US_i;
            r_repeat_us       <= REPEAT_US_i;
            r_bus_wave_cycles <= WAVE_CYCLEs_i;
            r_bus_wave_is_saw <= WAVE_IS_SAW_i;
            r_echo_us         <= '0;
            r_echo_valid      <= 1'b0;
            r_timeout         <= 1'b0;
         end else begin
            if (w_capture) begin
               r_echo_us    <= r_elapsed;
               r_echo_valid <= 1'b1;
            end
            if (w_listen_end) begin
               r_timeout <= !(r_echo_valid || w_capture);
            end
         end
      end
   end

   assign BUS_WAVE_CYCLEs_o = r_bus_wave_cycles;
   assign BUS_WAVE_IS_SAW_o = r_bus_wave_is_saw;
   assign TX_EN_o           = (r_state == ST_TX);
   assign BUSY_o            = (r_state != ST_IDLE);
   assign ECHO_US_o         = r_echo_us;
   assign ECHO_VALID_o      = r_echo_valid;
   assign TIMEOUT_o         = r_timeout;
   assign DONE_o            = r_done;
   assign STATE_o           = r_state;

endmodule

// File: tb/tb_ultrasonic_ping_sched.sv
// Self-checking bench for ultrasonic_ping_sched at a 4 MHz clock (1 us = 4 clocks).
module tb_ultrasonic_ping_sched;

   localparam int TW = 16;

   logic          ck = 1'b0;
   logic          rst, start, run, wave_is_saw, wave_wrap, echo;
   logic [7:0]    burst_n, wave_cycles;
   logic [TW-1:0] blank_us, listen_us, repeat_us;
   logic [7:0]    bus_wave_cycles;
   logic          bus_wave_is_saw, tx_en, busy, echo_valid, timeout, done;
   logic [TW-1:0] echo_us;
   logic [2:0]    state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit valid;
      bit tmo;
      int us_lo;
      int us_hi;
   } exp_t;
   exp_t sb_q[$];

   int cyc = 0;
   int tx_cyc = 0;
   int tx_high_cnt = 0;
   int rise_cnt = 0;
   int rise_prev = 0;
   int rise_last = 0;
   int done_cnt = 0;
   bit tx_prev = 1'b0;

   always #5 ck = ~ck;

   ultrasonic_ping_sched #(
      .C_F_CK   (4_000_000),
      .C_TIME_W (TW)
   ) dut (
      .CK_i              (ck),
      .RST_i             (rst),
      .START_i           (start),
      .RUN_i             (run),
      .BURST_N_i         (burst_n),
      .WAVE_CYCLEs_i     (wave_cycles),
      .WAVE_IS_SAW_i     (wave_is_saw),
      .BLANK_US_i        (blank_us),
      .LISTEN_US_i       (listen_us),
      .REPEAT_US_i       (repeat_us),
      .WAVE_WRAP_i       (wave_wrap),
      .ECHO_i            (echo),
      .BUS_WAVE_CYCLEs_o (bus_wave_cycles),
      .BUS_WAVE_IS_SAW_o (bus_wave_is_saw),
      .TX_EN_o           (tx_en),
      .BUSY_o            (busy),
      .ECHO_US_o         (echo_us),
      .ECHO_VALID_o      (echo_valid),
      .TIMEOUT_o         (timeout),
      .DONE_o            (done),
      .STATE_o           (state)
   );

   // Oscillator model: one wrap pulse at the end of every 5th TX clock.
   always @(negedge ck) begin
      cyc++;
      if (tx_en === 1'b1) begin
         tx_cyc++;
         tx_high_cnt++;
         wave_wrap = ((tx_cyc % 5) == 0);
         if (!tx_prev) begin
            rise_prev = rise_last;
            rise_last = cyc;
            rise_cnt++;
         end
         tx_prev = 1'b1;
      end else begin
         tx_cyc    = 0;
         wave_wrap = 1'b0;
         tx_prev   = 1'b0;
      end
   end

   // Scoreboard: each DONE pulse retires the oldest expected ping result.
   always @(negedge ck) begin
      if (done === 1'b1) begin
         done_cnt++;
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_done: DONE_o pulsed with no ping expected at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (echo_valid !== e.valid || timeout !== e.tmo ||
                int'(echo_us) < e.us_lo || int'(echo_us) > e.us_hi) begin
               n_fail++;
               $display("FAIL sb_ping_result: got valid=%0b timeout=%0b us=%0d, want valid=%0b timeout=%0b us in [%0d,%0d]",
                        echo_valid, timeout, echo_us, e.valid, e.tmo, e.us_lo, e.us_hi);
            end
         end
      end
   end

   task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge ck);
         if (state === st) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge ck) start = 1'b1;
      @(negedge ck) start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge ck);
      n_checks++;
      if ({tx_en, busy, echo_valid, timeout, done} !== 5'b0 || state !== 3'd0 ||
          echo_us !== '0 || bus_wave_cycles !== 8'h00 || bus_wave_is_saw !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: tx=%0b busy=%0b ev=%0b to=%0b done=%0b st=%0d us=%0d bus=%0h saw=%0b, want all 0",
                  tx_en, busy, echo_valid, timeout, done, state, echo_us, bus_wave_cycles, bus_wave_is_saw);
      end
      rst = 1'b0;
      @(negedge ck);
   endtask

   task automatic test_single_ping();
      bit ok;
      burst_n = 8'd3; blank_us = 16'd2; listen_us = 16'd10;
      wave_cycles = 8'h2A; wave_is_saw = 1'b1;
      tx_high_cnt = 0; done_cnt = 0;
      sb_q.push_back('{valid: 1'b1, tmo: 1'b0, us_lo: 7, us_hi: 9});
      pulse_start();
      n_checks++;
      if (state !== 3'd1 || tx_en !== 1'b1 || busy !== 1'b1 || bus_wave_cycles !== 8'h2A || bus_wave_is_saw !== 1'b1) begin
         n_fail++;
         $display("FAIL single_tx_entry: st=%0d tx=%0b busy=%0b bus=%0h saw=%0b, want st=1 tx=1 busy=1 bus=2a saw=1",
                  state, tx_en, busy, bus_wave_cycles, bus_wave_is_saw);
      end
      wave_cycles = 8'h55; wave_is_saw = 1'b0;
      repeat (31) @(negedge ck);
      echo = 1'b1;
      wait_state(3'd0, 200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_return_idle: state=%0d after budget, want 0", state);
      end
      n_checks++;
      if (tx_high_cnt !== 15) begin
         n_fail++;
         $display("FAIL single_tx_len: TX_EN_o high %0d clocks, want 15", tx_high_cnt);
      end
      @(negedge ck);
      n_checks++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL single_done_count: %0d DONE pulses, want 1", done_cnt);
      end
      n_checks++;
      if (bus_wave_cycles !== 8'h2A || bus_wave_is_saw !== 1'b1) begin
         n_fail++;
         $display("FAIL single_bus_hold: bus=%0h saw=%0b, want 2a/1", bus_wave_cycles, bus_wave_is_saw);
      end
      n_checks++;
      if (echo_valid !== 1'b1 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL single_flags_hold: ev=%0b to=%0b in IDLE, want 1/0", echo_valid, timeout);
      end
      echo = 1'b0;
      repeat (4) @(negedge ck);
   endtask

   task automatic test_no_echo();
      bit ok;
      burst_n = 8'd3; blank_us = 16'd2; listen_us = 16'd5;
      done_cnt = 0;
      sb_q.push_back('{valid: 1'b0, tmo: 1'b1, us_lo: 0, us_hi: 0});
      pulse_start();
      n_checks++;
      if (bus_wave_cycles !== 8'h55 || bus_wave_is_saw !== 1'b0 || echo_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL noecho_relatch: bus=%0h saw=%0b ev=%0b, want 55/0/0", bus_wave_cycles, bus_wave_is_saw, echo_valid);
      end
      wait_state(3'd0, 200, ok);
      @(negedge ck);
      n_checks++;
      if (!ok || done_cnt !== 1 || timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL noecho_end: idle=%0b done=%0d to=%0b, want 1/1/1", ok, done_cnt, timeout);
      end
   endtask

   task automatic test_repeat();
      bit ok;
      burst_n = 8'd2; blank_us = 16'd1; listen_us = 16'd2; repeat_us = 16'd3;
      rise_cnt = 0; done_cnt = 0;
      sb_q.push_back('{valid: 1'b0, tmo: 1'b1, us_lo: 0, us_hi: 0});
      sb_q.push_back('{valid: 1'b0, tmo: 1'b1, us_lo: 0, us_hi: 0});
      @(negedge ck) run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge ck);
         if (rise_cnt >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok || (rise_last - rise_prev) != 37) begin
         n_fail++;
         $display("FAIL repeat_period: got=%0b gap=%0d clocks, want 37", ok, rise_last - rise_prev);
      end
      wait_state(3'd4, 200, ok);
      run = 1'b0;
      @(negedge ck);
      n_checks++;
      if (!ok || state !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL repeat_stop: reached_holdoff=%0b state=%0d busy=%0b, want 1/0/0", ok, state, busy);
      end
      repeat (60) @(negedge ck);
      n_checks++;
      if (rise_cnt !== 2 || tx_en !== 1'b0 || done_cnt !== 2) begin
         n_fail++;
         $display("FAIL repeat_no_more_tx: rises=%0d tx=%0b dones=%0d, want 2/0/2", rise_cnt, tx_en, done_cnt);
      end
   endtask

   task automatic test_burst_zero();
      bit ok;
      burst_n = 8'd0; blank_us = 16'd0; listen_us = 16'd1;
      tx_high_cnt = 0;
      sb_q.push_back('{valid: 1'b0, tmo: 1'b1, us_lo: 0, us_hi: 0});
      pulse_start();
      n_checks++;
      if (state !== 3'd2 || tx_en !== 1'b0) begin
         n_fail++;
         $display("FAIL burst0_blank: state=%0d tx=%0b, want 2/0", state, tx_en);
      end
      @(negedge ck);
      n_checks++;
      if (state !== 3'd3) begin
         n_fail++;
         $display("FAIL burst0_blank_len: state=%0d after 1 clock, want 3", state);
      end
      wait_state(3'd0, 100, ok);
      n_checks++;
      if (!ok || tx_high_cnt !== 0) begin
         n_fail++;
         $display("FAIL burst0_no_tx: idle=%0b tx_clocks=%0d, want 1/0", ok, tx_high_cnt);
      end
      @(negedge ck);
   endtask

   task automatic test_edge_cases();
      bit ok;
      burst_n = 8'd1; blank_us = 16'd5; listen_us = 16'd2;
      rise_cnt = 0; done_cnt = 0;
      sb_q.push_back('{valid: 1'b0, tmo: 1'b1, us_lo: 0, us_hi: 0});
      pulse_start();
      wait_state(3'd2, 50, ok);
      echo = 1'b1;
      wait_state(3'd3, 100, ok);
      start = 1'b1;
      @(negedge ck) start = 1'b0;
      n_checks++;
      if (echo_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL blank_echo_ignored: ECHO_VALID_o=%0b in LISTEN, want 0", echo_valid);
      end
      wait_state(3'd0, 100, ok);
      repeat (20) @(negedge ck);
      n_checks++;
      if (!ok || state !== 3'd0 || rise_cnt !== 1 || done_cnt !== 1) begin
         n_fail++;
         $display("FAIL start_dropped: idle=%0b state=%0d tx_entries=%0d dones=%0d, want 1/0/1/1",
                  ok, state, rise_cnt, done_cnt);
      end
      echo = 1'b0;
      repeat (4) @(negedge ck);
   endtask

   task automatic test_reset_mid_ping();
      bit ok;
      burst_n = 8'd4; blank_us = 16'd1; listen_us = 16'd3;
      wave_cycles = 8'h77; wave_is_saw = 1'b1;
      pulse_start();
      repeat (2) @(negedge ck);
      rst = 1'b1;
      @(negedge ck);
      n_checks++;
      if (tx_en !== 1'b0 || busy !== 1'b0 || state !== 3'd0 || echo_valid !== 1'b0 ||
          timeout !== 1'b0 || done !== 1'b0 || bus_wave_cycles !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_abort: tx=%0b busy=%0b st=%0d ev=%0b to=%0b done=%0b bus=%0h, want all 0",
                  tx_en, busy, state, echo_valid, timeout, done, bus_wave_cycles);
      end
      rst = 1'b0;
      burst_n = 8'd1; done_cnt = 0; tx_high_cnt = 0;
      sb_q.push_back('{valid: 1'b1, tmo: 1'b0, us_lo: 2, us_hi: 3});
      pulse_start();
      wait_state(3'd3, 100, ok);
      echo = 1'b1;
      wait_state(3'd0, 100, ok);
      @(negedge ck);
      n_checks++;
      if (!ok || done_cnt !== 1 || tx_high_cnt !== 5 || bus_wave_cycles !== 8'h77) begin
         n_fail++;
         $display("FAIL reset_clean_ping: idle=%0b dones=%0d tx_clocks=%0d bus=%0h, want 1/1/5/77",
                  ok, done_cnt, tx_high_cnt, bus_wave_cycles);
      end
      echo = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; run = 1'b0; echo = 1'b0;
      burst_n = '0; wave_cycles = '0; wave_is_saw = 1'b0;
      blank_us = '0; listen_us = '0; repeat_us = '0;
      test_reset();
      test_single_ping();
      test_no_echo();
      test_repeat();
      test_burst_zero();
      test_edge_cases();
      test_reset_mid_ping();
      repeat (4) @(negedge ck);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d expected pings never completed, want 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
